// File: rtl/vga_pkg.sv
// Shared definitions for the VGA capture block: counter/pixel widths,
// FSM state encoding and a window-span helper.
package vga_pkg;

    localparam int CNT_W = 11;
    localparam int RGB_W = 3;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_SEEK    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    // True when lo <= v < lo+len, evaluated one bit wider so the sum cannot wrap.
    function automatic logic in_span(input logic [CNT_W-1:0] v,
                                     input logic [CNT_W-1:0] lo,
                                     input logic [CNT_W-1:0] len);
        logic [CNT_W:0] v_x;
        logic [CNT_W:0] lo_x;
        logic [CNT_W:0] hi_x;
        v_x  = {1'b0, v};
        lo_x = {1'b0, lo};
        hi_x = lo_x + {1'b0, len};
        return (v_x >= lo_x) && (v_x < hi_x);
    endfunction

endpackage

// File: rtl/vga_sync_detect.sv
// Synchronizes syncs and pixel together, detects sync falling edges and
// runs the saturating horizontal/vertical position counters.
import vga_pkg::*;

module vga_sync_detect (
    input  logic             clk,
    input  logic             rst,
    input  logic             hsync_i,
    input  logic             vsync_i,
    input  logic [RGB_W-1:0] rgb_i,
    output logic             h_edge_o,
    output logic             v_edge_o,
    output logic [CNT_W-1:0] h_cnt_o,
    output logic [CNT_W-1:0] v_cnt_o,
    output logic [RGB_W-1:0] rgb_o
);

    localparam int BUS_W = RGB_W + 2;
    localparam logic [BUS_W-1:0] BUS_RST = {2'b11, {RGB_W{1'b0}}};

    logic [BUS_W-1:0] meta_q;
    logic [BUS_W-1:0] sync_q;
    logic             hs_prev_q;
    logic             vs_prev_q;
    logic [RGB_W-1:0] rgb_q;
    logic [CNT_W-1:0] h_cnt_q;
    logic [CNT_W-1:0] h_cnt_d;
    logic [CNT_W-1:0] v_cnt_q;
    logic [CNT_W-1:0] v_cnt_d;
    logic             h_fall;
    logic             v_fall;

    assign h_fall = hs_prev_q & ~sync_q[BUS_W-1];
    assign v_fall = vs_prev_q & ~sync_q[BUS_W-2];

    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (h_fall) begin
            h_cnt_d = '0;
        end else if (h_cnt_q != CNT_MAX) begin
            h_cnt_d = h_cnt_q + CNT_ONE;
        end
        if (v_fall) begin
            v_cnt_d = '0;
        end else if (h_fall && (v_cnt_q != CNT_MAX)) begin
            v_cnt_d = v_cnt_q + CNT_ONE;
        end
    end

    // The pixel takes the same extra stage as the edge detect so that
    // rgb_o is the pixel belonging to the current h_cnt/v_cnt value.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q    <= BUS_RST;
            sync_q    <= BUS_RST;
            hs_prev_q <= 1'b1;
            vs_prev_q <= 1'b1;
            rgb_q     <= '0;
            h_cnt_q   <= '0;
            v_cnt_q   <= '0;
        end else begin
            meta_q    <= {hsync_i, vsync_i, rgb_i};
            sync_q    <= meta_q;
            hs_prev_q <= sync_q[BUS_W-1];
            vs_prev_q <= sync_q[BUS_W-2];
            rgb_q     <= sync_q[RGB_W-1:0];
            h_cnt_q   <= h_cnt_d;
            v_cnt_q   <= v_cnt_d;
        end
    end

    assign h_edge_o = h_fall;
    assign v_edge_o = v_fall;
    assign h_cnt_o  = h_cnt_q;
    assign v_cnt_o  = v_cnt_q;
    assign rgb_o    = rgb_q;

endmodule

// File: rtl/vga_capture.sv
// Locks onto an incoming VGA timing, measures line/frame length and writes
// a rectangular window of each frame into an external frame store.
import vga_pkg::*;

module vga_capture #(
    parameter logic [CNT_W-1:0] CAP_X0 = 11'd216,
    parameter logic [CNT_W-1:0] CAP_Y0 = 11'd27,
    parameter logic [CNT_W-1:0] CAP_W  = 11'd64,
    parameter logic [CNT_W-1:0] CAP_H  = 11'd32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hsync_in,
    input  logic             vsync_in,
    input  logic [RGB_W-1:0] rgb_in,
    output logic             wr_en,
    output logic [CNT_W-1:0] wr_addr,
    output logic [RGB_W-1:0] wr_data,
    output logic             locked,
    output logic             frame_done,
    output logic [CNT_W-1:0] h_total,
    output logic [CNT_W-1:0] v_total,
    output logic             sync_err
);

    localparam int TOTAL = int'(CAP_W) * int'(CAP_H);
    localparam logic [CNT_W-1:0] LAST_ADDR = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W:0]   LEN_ONE   = (CNT_W+1)'(1);

    logic             h_edge;
    logic             v_edge;
    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic [RGB_W-1:0] rgb_p;

    vga_sync_detect u_sync (
        .clk      (clk),
        .rst      (rst),
        .hsync_i  (hsync_in),
        .vsync_i  (vsync_in),
        .rgb_i    (rgb_in),
        .h_edge_o (h_edge),
        .v_edge_o (v_edge),
        .h_cnt_o  (h_cnt),
        .v_cnt_o  (v_cnt),
        .rgb_o    (rgb_p)
    );

    state_t           state_q;
    logic             h_meas_q;
    logic             arm_q;
    logic             locked_q;
    logic             sync_err_q;
    logic [CNT_W-1:0] h_total_q;
    logic [CNT_W-1:0] v_total_q;
    logic [CNT_W:0]   h_len;
    logic [CNT_W:0]   v_len;
    logic             lose_lock;

    assign h_len     = {1'b0, h_cnt} + LEN_ONE;
    assign v_len     = {1'b0, v_cnt} + LEN_ONE;
    assign lose_lock = (h_cnt == CNT_MAX) || (v_cnt == CNT_MAX)
                    || (h_edge && (h_len != {1'b0, h_total_q}))
                    || (v_edge && (v_len != {1'b0, v_total_q}));

    // arm_q is only set by a vsync edge seen while already locked, so the
    // frame that was running when lock was achieved is never captured.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_SEEK;
            h_meas_q   <= 1'b0;
            arm_q      <= 1'b0;
            locked_q   <= 1'b0;
            sync_err_q <= 1'b0;
            h_total_q  <= '0;
            v_total_q  <= '0;
        end else begin
            sync_err_q <= 1'b0;
            case (state_q)
                ST_SEEK: begin
                    if (v_edge) begin
                        state_q  <= ST_MEASURE;
                        h_meas_q <= 1'b0;
                    end
                end
                ST_MEASURE: begin
                    if ((h_cnt == CNT_MAX) || (v_cnt == CNT_MAX)) begin
                        state_q <= ST_SEEK;
                    end else begin
                        if (h_edge && !h_meas_q) begin
                            h_total_q <= h_len[CNT_W-1:0];
                            h_meas_q  <= 1'b1;
                        end
                        if (v_edge) begin
                            v_total_q <= v_len[CNT_W-1:0];
                            state_q   <= ST_LOCKED;
                            locked_q  <= 1'b1;
                            arm_q     <= 1'b0;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (lose_lock) begin
                        state_q    <= ST_SEEK;
                        locked_q   <= 1'b0;
                        arm_q      <= 1'b0;
                        sync_err_q <= 1'b1;
                    end else if (v_edge) begin
                        arm_q <= 1'b1;
                    end
                end
                default: begin
                    state_q  <= ST_SEEK;
                    locked_q <= 1'b0;
                    arm_q    <= 1'b0;
                end
            endcase
        end
    end

    logic             win_q;
    logic [RGB_W-1:0] pix_q;
    logic [CNT_W-1:0] col_q;
    logic [CNT_W-1:0] row_base_q;
    logic             full_q;
    logic             wr_en_q;
    logic [CNT_W-1:0] wr_addr_q;
    logic [CNT_W-1:0] wr_addr_d;
    logic [RGB_W-1:0] wr_data_q;
    logic             frame_done_q;
    logic             in_window;
    logic             do_write;

    assign in_window = in_span(h_cnt, CAP_X0, CAP_W) && in_span(v_cnt, CAP_Y0, CAP_H);
    assign do_write  = win_q && (state_q == ST_LOCKED) && !full_q;
    assign wr_addr_d = row_base_q + col_q;

    // row_base_q tracks row*CAP_W by repeated addition; full_q blocks any
    // write past the last address until the next frame starts.
    always_ff @(posedge clk) begin
        if (rst) begin
            win_q        <= 1'b0;
            pix_q        <= '0;
            col_q        <= '0;
            row_base_q   <= '0;
            full_q       <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            win_q        <= (state_q == ST_LOCKED) && arm_q && in_window;
            pix_q        <= rgb_p;
            wr_en_q      <= 1'b0;
            frame_done_q <= wr_en_q && (wr_addr_q == LAST_ADDR);
            if (v_edge) begin
                col_q      <= '0;
                row_base_q <= '0;
                full_q     <= 1'b0;
            end else if (do_write) begin
                wr_en_q   <= 1'b1;
                wr_addr_q <= wr_addr_d;
                wr_data_q <= pix_q;
                if (wr_addr_d == LAST_ADDR) begin
                    col_q      <= '0;
                    row_base_q <= '0;
                    full_q     <= 1'b1;
                end else if (col_q == (CAP_W - CNT_ONE)) begin
                    col_q      <= '0;
                    row_base_q <= row_base_q + CAP_W;
                end else begin
                    col_q <= col_q + CNT_ONE;
                end
            end
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign locked     = locked_q;
    assign frame_done = frame_done_q;
    assign h_total    = h_total_q;
    assign v_total    = v_total_q;
    assign sync_err   = sync_err_q;

endmodule

// File: tb/tb_vga_capture.sv
// Bench for vga_capture in a small window mode: 20 clk/line, 10 lines/frame,
// window x=2..5, y=1..2; frame-level vectors plus a write scoreboard.
module tb_vga_capture;

    localparam int LINES     = 10;
    localparam int K_NORMAL  = 0;
    localparam int K_BADLINE = 1;
    localparam int K_HOLD    = 2;
    localparam int K_RESET   = 3;
    localparam int NVEC      = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        hsync_in;
    logic        vsync_in;
    logic [2:0]  rgb_in;
    logic        wr_en;
    logic [10:0] wr_addr;
    logic [2:0]  wr_data;
    logic        locked;
    logic        frame_done;
    logic [10:0] h_total;
    logic [10:0] v_total;
    logic        sync_err;

    always #5 clk = ~clk;

    vga_capture #(
        .CAP_X0 (11'd2),
        .CAP_Y0 (11'd1),
        .CAP_W  (11'd4),
        .CAP_H  (11'd2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .rgb_in     (rgb_in),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .locked     (locked),
        .frame_done (frame_done),
        .h_total    (h_total),
        .v_total    (v_total),
        .sync_err   (sync_err)
    );

    typedef struct {
        logic [10:0] addr;
        logic [2:0]  data;
        int          cyc;
    } exp_t;

    typedef struct {
        int kind;
        bit cap;
        bit lock;
        int serr;
        int fd;
        int ht;
        int vt;
    } vec_t;

    exp_t sb_q[$];
    vec_t tbl[NVEC];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   serr_cnt = 0;
    int   fd_cnt   = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_wr_en"},      int'(wr_en),      0);
        chk({tag, "_locked"},     int'(locked),     0);
        chk({tag, "_frame_done"}, int'(frame_done), 0);
        chk({tag, "_sync_err"},   int'(sync_err),   0);
        chk({tag, "_wr_addr"},    int'(wr_addr),    0);
        chk({tag, "_wr_data"},    int'(wr_data),    0);
        chk({tag, "_h_total"},    int'(h_total),    0);
        chk({tag, "_v_total"},    int'(v_total),    0);
    endtask

    // Write monitor: every strobe must match the oldest expected pixel,
    // including the cycle it was due (4 clk after its rgb_in sample).
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (wr_en) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_write_addr", int'(wr_addr), -1);
            end else begin
                e = sb_q.pop_front();
                chk("write_addr", int'(wr_addr), int'(e.addr));
                chk("write_data", int'(wr_data), int'(e.data));
                chk("write_latency_cycle", cyc, e.cyc);
                $display("write addr=%0d data=%0d cyc=%0d", wr_addr, wr_data, cyc);
            end
        end
        if (sync_err) serr_cnt++;
        if (frame_done) fd_cnt++;
    end

    task automatic drive_frame(input int kind, input bit cap_in);
        bit   cap;
        int   len;
        exp_t e;
        cap = cap_in;
        for (int line = 0; line < LINES; line++) begin
            len = (kind == K_BADLINE && line == 5) ? 21 : 20;
            for (int pos = 0; pos < len; pos++) begin
                @(negedge clk);
                if (kind == K_RESET && line == 1 && pos == 8) chk_reset_vals("midreset");
                hsync_in = (pos >= 2);
                vsync_in = !(line == 0 && pos < 3);
                rgb_in   = 3'(pos);
                if (cap && line >= 1 && line <= 2 && pos >= 2 && pos <= 5) begin
                    e.addr = 11'((line - 1) * 4 + (pos - 2));
                    e.data = 3'(pos);
                    e.cyc  = cyc + 5;
                    sb_q.push_back(e);
                end
                if (kind == K_RESET && line == 1) begin
                    if (pos == 7) begin
                        rst = 1'b1;
                        sb_q.delete();
                        cap = 1'b0;
                    end
                    if (pos == 9) rst = 1'b0;
                end
            end
        end
    endtask

    task automatic hold_syncs(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            hsync_in = 1'b1;
            vsync_in = 1'b1;
            rgb_in   = 3'd0;
        end
    endtask

    initial begin
        rst      = 1'b1;
        hsync_in = 1'b1;
        vsync_in = 1'b1;
        rgb_in   = 3'd0;

        //            kind       cap   lock  serr fd  ht  vt
        tbl[0]  = '{K_NORMAL,  1'b0, 1'b0, 0, 0, 20, 0};
        tbl[1]  = '{K_NORMAL,  1'b0, 1'b1, 0, 0, 20, 10};
        tbl[2]  = '{K_NORMAL,  1'b1, 1'b1, 0, 1, 20, 10};
        tbl[3]  = '{K_NORMAL,  1'b1, 1'b1, 0, 1, 20, 10};
        tbl[4]  = '{K_BADLINE, 1'b1, 1'b0, 1, 1, 20, 10};
        tbl[5]  = '{K_NORMAL,  1'b0, 1'b0, 0, 0, 20, 10};
        tbl[6]  = '{K_NORMAL,  1'b0, 1'b1, 0, 0, 20, 10};
        tbl[7]  = '{K_NORMAL,  1'b1, 1'b1, 0, 1, 20, 10};
        tbl[8]  = '{K_HOLD,    1'b0, 1'b0, 1, 0, 20, 10};
        tbl[9]  = '{K_NORMAL,  1'b0, 1'b0, 0, 0, 20, 10};
        tbl[10] = '{K_NORMAL,  1'b0, 1'b1, 0, 0, 20, 10};
        tbl[11] = '{K_RESET,   1'b1, 1'b0, 0, 0, 0,  0};
        tbl[12] = '{K_NORMAL,  1'b0, 1'b0, 0, 0, 20, 0};
        tbl[13] = '{K_NORMAL,  1'b0, 1'b1, 0, 0, 20, 10};
        tbl[14] = '{K_NORMAL,  1'b1, 1'b1, 0, 1, 20, 10};

        repeat (3) @(negedge clk);
        chk_reset_vals("por");
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            serr_cnt = 0;
            fd_cnt   = 0;
            if (tbl[i].kind == K_HOLD) hold_syncs(2100);
            else drive_frame(tbl[i].kind, tbl[i].cap);
            chk($sformatf("vec%0d_locked", i),     int'(locked),  int'(tbl[i].lock));
            chk($sformatf("vec%0d_sync_err", i),   serr_cnt,      tbl[i].serr);
            chk($sformatf("vec%0d_frame_done", i), fd_cnt,        tbl[i].fd);
            chk($sformatf("vec%0d_h_total", i),    int'(h_total), tbl[i].ht);
            chk($sformatf("vec%0d_v_total", i),    int'(v_total), tbl[i].vt);
            chk($sformatf("vec%0d_pending", i),    sb_q.size(),   0);
            $display("vec %0d kind=%0d locked=%0d sync_err=%0d frame_done=%0d h_total=%0d v_total=%0d",
                     i, tbl[i].kind, locked, serr_cnt, fd_cnt, h_total, v_total);
        end

        hold_syncs(10);
        chk("final_pending", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
